// File: rtl/uart_tx_fifo_if.sv
// Byte-write interface of the buffered UART transmitter.
//   start    : write strobe from the requester
//   data     : byte sampled with start
//   full     : FIFO holds FIFO_DEPTH bytes
//   busy     : start | FIFO non-empty | frame in progress
//   level    : bytes waiting in the FIFO (excludes the byte being shifted)
//   overflow : sticky flag, a write was attempted while full
// master = requester side, slave = transmitter side.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             start;
    logic [7:0]       data;
    logic             full;
    logic             busy;
    logic [LVL_W-1:0] level;
    logic             overflow;

    modport master (
        output start, data,
        input  full, busy, level, overflow
    );

    modport slave (
        input  start, data,
        output full, busy, level, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes written through the bus interface are
// queued in a FIFO_DEPTH-entry FIFO and sent as back-to-back 8N1 frames,
// LSB first, with a bit period of DIV = CLOCK_FREQ/BAUD clock cycles.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous, active-low reset
//   bus   : uart_tx_fifo_if.slave (start, data, full, busy, level, overflow)
//   tx    : serial line, idle high, registered
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit (11*DIV cycles per frame).
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus,
    output logic          tx
);
    localparam int DIV   = CLOCK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [7:0] mem [FIFO_DEPTH];
    logic [7:0] head;
    logic       full, empty, push, pop, bit_end;

    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push    = bus.start && !full;
    assign head    = mem[rd_ptr_q];
    assign bit_end = (cnt_q == '0);

    // Transmit FSM. Popping in STOP (not only in IDLE) is what keeps
    // consecutive frames contiguous with no idle bit between them.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                    tx_d     = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    cnt_d   = CNT_LOAD;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = CNT_LOAD;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // Next bit is shift_q[1], which becomes shift[0].
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = CNT_LOAD;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        shift_d  = head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                        tx_d     = 1'b0;
                        cnt_d    = CNT_LOAD;
                        state_d  = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // FIFO bookkeeping. Pointers wrap naturally since FIFO_DEPTH is a
    // power of two; level saturates by construction (push needs !full).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (bus.start & full);
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Data-only registers: their content is irrelevant until a pop loads them.
    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
        if (push) mem[wr_ptr_q] <= bus.data;
    end

    assign tx           = tx_q;
    assign bus.full     = full;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = bus.start | !empty | (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int CF  = 800;
    localparam int BD  = 100;
    localparam int DIV = CF / BD;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FLEN = FB * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Two instances: a 32-deep one and a 4-deep one; sel picks which is driven/observed.
    uart_tx_fifo_if #(.FIFO_DEPTH(32)) bus_a ();
    uart_tx_fifo_if #(.FIFO_DEPTH(4))  bus_b ();
    logic tx_a, tx_b;

    uart_tx_fifo #(.CLOCK_FREQ(CF), .BAUD(BD), .FIFO_DEPTH(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .tx(tx_a));
    uart_tx_fifo #(.CLOCK_FREQ(CF), .BAUD(BD), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .tx(tx_b));

    logic       sel = 1'b0;
    logic       start_v = 1'b0;
    logic [7:0] data_v = 8'h00;

    assign bus_a.start = !sel & start_v;
    assign bus_a.data  = data_v;
    assign bus_b.start = sel & start_v;
    assign bus_b.data  = data_v;

    logic       obs_tx, obs_busy, obs_full, obs_ovf;
    logic [5:0] obs_level;
    assign obs_tx    = sel ? tx_b : tx_a;
    assign obs_busy  = sel ? bus_b.busy : bus_a.busy;
    assign obs_full  = sel ? bus_b.full : bus_a.full;
    assign obs_ovf   = sel ? bus_b.overflow : bus_a.overflow;
    assign obs_level = sel ? {3'b000, bus_b.level} : bus_a.level;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    // Reference model: a byte queue plus "which frame, how far into it".
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    int         m_depth = 32;
    bit         m_in = 0;
    logic [7:0] m_byte = 8'h00;
    int         m_pos = 0;
    bit         m_ovf = 0;

    function automatic int m_tx();
        int b;
        if (!m_in) return 1;
        b = m_pos / DIV;
        if (b == 0) return 0;
        if (b <= 8) return int'(m_byte[b-1]);
`ifdef UART_TX_PARITY_EN
        if (b == 9) return int'(^m_byte);
`endif
        return 1;
    endfunction

    task automatic m_edge(input logic s, input logic [7:0] d);
        bit can_pop, was_full;
        can_pop  = !m_in || (m_pos == FLEN - 1);
        was_full = (m_q.size() == m_depth);
        if (m_in) m_pos++;
        if (can_pop) begin
            if (m_q.size() > 0) begin
                m_byte = m_q.pop_front();
                m_in   = 1;
                m_pos  = 0;
            end else begin
                m_in = 0;
            end
        end
        if (s) begin
            if (was_full) m_ovf = 1;
            else begin
                m_q.push_back(d);
                m_sent.push_back(d);
            end
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_in  = 0;
        m_pos = 0;
        m_ovf = 0;
    endtask

    // Independent line receiver: samples each bit in the middle of its period.
    logic [7:0] rx_q[$];
    logic       rx_par_q[$];
    bit         rx_on = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_sr = 8'h00;
    int         rx_stop_bad = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_on  = 0;
            rx_cnt = 0;
        end else if (!rx_on) begin
            if (obs_tx == 1'b0) begin
                rx_on  = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % DIV == DIV / 2) begin
                if (rx_cnt / DIV >= 1 && rx_cnt / DIV <= 8) rx_sr[rx_cnt/DIV-1] = obs_tx;
`ifdef UART_TX_PARITY_EN
                if (rx_cnt / DIV == 9) rx_par_q.push_back(obs_tx);
`endif
                if (rx_cnt / DIV == FB - 1) begin
                    rx_q.push_back(rx_sr);
                    if (obs_tx !== 1'b1) rx_stop_bad++;
                end
            end
            if (rx_cnt == FLEN - 1) rx_on = 0;
        end
    end

    logic last_tx, last_busy, last_full, last_ovf;
    int   last_level;

    // One clock cycle: apply inputs, compare against the model away from the edge, advance.
    task automatic cyc(input logic s, input logic [7:0] d);
        start_v = s;
        data_v  = d;
        @(negedge clk);
        chk("tx", int'(obs_tx), m_tx());
        chk("level", int'(obs_level), m_q.size());
        chk("full", int'(obs_full), int'(m_q.size() == m_depth));
        chk("overflow", int'(obs_ovf), int'(m_ovf));
        chk("busy", int'(obs_busy), int'(s || m_q.size() > 0 || m_in));
        last_tx = obs_tx; last_busy = obs_busy; last_full = obs_full;
        last_ovf = obs_ovf; last_level = int'(obs_level);
        @(posedge clk);
        m_edge(s, d);
        #1;
    endtask

    typedef struct {
        logic s; logic [7:0] d; int lvl; logic full; logic ovf; logic busy; logic tx;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] msg[$];
        logic [7:0] exp_bits[8];
        logic       txlog[100];
        logic       busylog[100];
        string      s;
        int         n, lows;
        bit         run;

        exp_bits = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[0] = '{1'b1, 8'h01, 0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 8'h02, 1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 8'h03, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h04, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h05, 3, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'h06, 4, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 4, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 4, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state of both instances
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            chk("reset_tx", int'(obs_tx), 1);
            chk("reset_level", int'(obs_level), 0);
            chk("reset_full", int'(obs_full), 0);
            chk("reset_overflow", int'(obs_ovf), 0);
            chk("reset_busy", int'(obs_busy), 0);
        end
        sel = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single byte 0x4E
        rx_q.delete();
        cyc(1'b1, 8'h4E);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 8'h00);
            txlog[i] = last_tx;
            busylog[i] = last_busy;
        end
        n = 0; run = 1;
        for (int i = 0; i < 100; i++) begin
            if (run && busylog[i]) n++;
            else run = 0;
        end
        chk("single_busy_len", n, FLEN + 1);
        chk("single_pre_start", int'(txlog[0]), 1);
        chk("single_start_first", int'(txlog[1]), 0);
        chk("single_start_last", int'(txlog[DIV]), 0);
        for (int b = 0; b < 8; b++) begin
            chk("single_bit_first", int'(txlog[1 + DIV*(b+1)]), int'(exp_bits[b]));
            chk("single_bit_last", int'(txlog[DIV*(b+2)]), int'(exp_bits[b]));
        end
        chk("single_stop", int'(txlog[1 + DIV*(FB-1)]), 1);
        chk("single_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("single_rx_byte", int'(rx_q[0]), 8'h4E);

        // Burst of 22 bytes into the 32-deep instance
        s = "No hay mas porciones";
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
        msg.push_back(8'h0D);
        msg.push_back(8'h0A);
        rx_q.delete();
        n = 0;
        foreach (msg[i]) begin
            cyc(1'b1, msg[i]);
            if (last_busy) n++;
        end
        for (int i = 0; i < 22*FLEN + 30; i++) begin
            cyc(1'b0, 8'h00);
            if (last_busy) n++;
        end
        chk("burst_busy_cycles", n, 22*FLEN + 2);
        chk("burst_rx_count", rx_q.size(), 22);
        for (int i = 0; i < 22 && i < rx_q.size(); i++) chk("burst_rx_byte", int'(rx_q[i]), int'(msg[i]));
        if (rx_q.size() > 0) chk("burst_last_byte", int'(rx_q[rx_q.size()-1]), 8'h0A);
        chk("burst_overflow", int'(obs_ovf), 0);

        // Push/pop collision at the end of a stop bit with level = 1
        rx_q.delete();
        cyc(1'b1, 8'h3C);
        cyc(1'b1, 8'hC3);
        repeat (FLEN - 1) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h5A);
        chk("collide_level_before", last_level, 1);
        chk("collide_stop_bit", int'(last_tx), 1);
        cyc(1'b0, 8'h00);
        chk("collide_level_after", last_level, 1);
        chk("collide_no_idle_bit", int'(last_tx), 0);
        repeat (2*FLEN + 20) cyc(1'b0, 8'h00);
        chk("collide_rx_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("collide_rx0", int'(rx_q[0]), 8'h3C);
            chk("collide_rx1", int'(rx_q[1]), 8'hC3);
            chk("collide_rx2", int'(rx_q[2]), 8'h5A);
        end

`ifdef UART_TX_PARITY_EN
        rx_par_q.delete();
        cyc(1'b1, 8'h07);
        repeat (FLEN + 10) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h03);
        repeat (FLEN + 10) cyc(1'b0, 8'h00);
        chk("parity_count", rx_par_q.size(), 2);
        if (rx_par_q.size() == 2) begin
            chk("parity_07", int'(rx_par_q[0]), 1);
            chk("parity_03", int'(rx_par_q[1]), 0);
        end
`endif

        // Overflow on the 4-deep instance, table-driven
        sel = 1'b1;
        m_depth = 4;
        #1;
        rx_q.delete();
        for (int k = 0; k < 8; k++) begin
            cyc(vecs[k].s, vecs[k].d);
            chk("ovf_tbl_level", last_level, vecs[k].lvl);
            chk("ovf_tbl_full", int'(last_full), int'(vecs[k].full));
            chk("ovf_tbl_overflow", int'(last_ovf), int'(vecs[k].ovf));
            chk("ovf_tbl_busy", int'(last_busy), int'(vecs[k].busy));
            chk("ovf_tbl_tx", int'(last_tx), int'(vecs[k].tx));
        end
        repeat (5*FLEN + 10) cyc(1'b0, 8'h00);
        chk("ovf_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("ovf_rx_byte", int'(rx_q[i]), i + 1);
        chk("ovf_sticky", int'(obs_ovf), 1);

        // Reset during data bit 3 of 0xA5 with two bytes queued
        rx_q.delete();
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        repeat (33) cyc(1'b0, 8'h00);
        @(negedge clk);
        chk("rst_mid_level_before", int'(obs_level), 2);
        chk("rst_mid_bit3", int'(obs_tx), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", int'(obs_tx), 1);
        chk("rst_mid_level", int'(obs_level), 0);
        chk("rst_mid_busy", int'(obs_busy), 0);
        chk("rst_mid_overflow", int'(obs_ovf), 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 3*FLEN; i++) begin
            cyc(1'b0, 8'h00);
            if (!last_tx) lows++;
        end
        chk("rst_mid_idle_after", lows, 0);
        chk("rst_mid_rx_empty", rx_q.size(), 0);

        // Randomized traffic on the 4-deep instance against the model
        rx_q.delete();
        m_sent.delete();
        for (int i = 0; i < 2000; i++) begin
            if (((i / 250) % 2) == 0) cyc(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, 8'($urandom));
            else cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, 8'($urandom));
        end
        repeat (5*FLEN + 10) cyc(1'b0, 8'h00);
        chk("rand_rx_count", rx_q.size(), m_sent.size());
        for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
            chk("rand_rx_byte", int'(rx_q[i]), int'(m_sent[i]));
        chk("stop_bits_high", rx_stop_bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
